// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: width default, opcode encoding and flag bundle.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SLT = 3'b111
    } opcode_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and status flags from two operands and an opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    input  opcode_e          op,
    output logic [WIDTH-1:0] res,
    output flags_t           fl
);

    logic [WIDTH:0] ext;
    logic [WIDTH:0] shl_ext;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        res      = '0;
        fl       = '0;
        ext      = '0;
        shl_ext  = '0;
        case (op)
            OP_ADD: begin
                ext      = {1'b0, aa} + {1'b0, bb};
                res      = ext[WIDTH-1:0];
                fl.carry = ext[WIDTH];
                fl.ovf   = (aa[WIDTH-1] == bb[WIDTH-1]) && (res[WIDTH-1] != aa[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry-out of aa + ~bb + 1 is 1 when there is no borrow, so invert it.
                ext      = {1'b0, aa} + {1'b0, ~bb} + {{WIDTH{1'b0}}, 1'b1};
                res      = ext[WIDTH-1:0];
                fl.carry = ~ext[WIDTH];
                fl.ovf   = (aa[WIDTH-1] != bb[WIDTH-1]) && (res[WIDTH-1] != aa[WIDTH-1]);
            end
            OP_AND: res = aa & bb;
            OP_OR:  res = aa | bb;
            OP_XOR: res = aa ^ bb;
            OP_NOT: res = ~aa;
            OP_SHL: begin
                // One spare bit above the result catches the last bit shifted out.
                shl_ext  = {1'b0, aa} << bb[3:0];
                res      = shl_ext[WIDTH-1:0];
                fl.carry = shl_ext[WIDTH];
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(aa) < $signed(bb))};
            default: res = '0;
        endcase
        fl.zero = (res == '0);
        fl.neg  = res[WIDTH-1];
    end

endmodule

// File: rtl/alu_in.sv
// Execute-stage ALU: one-cycle registered result and flags, synchronous active-low reset.
module alu_in
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    logic [WIDTH-1:0] res;
    flags_t           fl;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .aa  (aa),
        .bb  (bb),
        .op  (opcode_e'(op)),
        .res (res),
        .fl  (fl)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            sum   <= res;
            carry <= fl.carry;
            zero  <= fl.zero;
            neg   <= fl.neg;
            ovf   <= fl.ovf;
        end
    end

endmodule

// File: tb/tb_alu_in.sv
// Bench for alu_in: directed plan with literal expectations, then random ops against an integer model.
module tb_alu_in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] aa = '0;
    logic [15:0] bb = '0;
    logic [2:0]  op = '0;
    logic [15:0] sum;
    logic        carry, zero, neg, ovf;

    int total  = 0;
    int passed = 0;

    logic        have_exp = 1'b0;
    logic [19:0] exp_val;
    string       exp_tag;

    alu_in dut (
        .clk   (clk),
        .rst_n (rst_n),
        .aa    (aa),
        .bb    (bb),
        .op    (op),
        .sum   (sum),
        .carry (carry),
        .zero  (zero),
        .neg   (neg),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] pk(input logic [15:0] s, input bit c, z, n, v);
        return {s, c, z, n, v};
    endfunction

    localparam logic [19:0] RST_VAL = {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reference model in plain integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, b, input logic [2:0] o);
        int ua, ub, sa, sb, r, n;
        bit c, v;
        logic [15:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 0;
        v = 0;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            3'd1: begin r = ua - ub; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ~ua;
            3'd6: begin n = ub % 16; r = ua << n; c = (n != 0) && (((ua >> (16 - n)) & 1) == 1); end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        res = 16'(r);
        return pk(res, c, res == 16'h0, res[15], v);
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: got sum=%h c/z/n/v=%b required sum=%h c/z/n/v=%b",
                    tag, got[19:4], got[3:0], want[19:4], want[3:0]);
    endtask

    // One cycle: check the result of the previous cycle's inputs, then present new inputs.
    task automatic step(input string tag, input logic [15:0] a, b, input logic [2:0] o,
                        input logic r, input logic [19:0] want);
        @(negedge clk);
        if (have_exp) check(exp_tag, {sum, carry, zero, neg, ovf}, exp_val);
        aa = a;
        bb = b;
        op = o;
        rst_n = r;
        exp_val = want;
        exp_tag = tag;
        have_exp = 1'b1;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [2:0]  ro;

        step("reset0", 16'h1234, 16'h0001, 3'd0, 1'b0, RST_VAL);
        step("reset1", 16'h1234, 16'h0001, 3'd0, 1'b0, RST_VAL);

        for (int i = 0; i < 10; i++)
            step($sformatf("add_sweep%0d", i), 16'(i), 16'h0001, 3'd0, 1'b1,
                 pk(16'(i + 1), 0, 0, 0, 0));

        step("add_wrap",  16'hFFFF, 16'h0001, 3'd0, 1'b1, pk(16'h0000, 1, 1, 0, 0));
        step("add_ovf",   16'h7FFF, 16'h0001, 3'd0, 1'b1, pk(16'h8000, 0, 0, 1, 1));
        step("sub_borrow",16'h0005, 16'h0007, 3'd1, 1'b1, pk(16'hFFFE, 1, 0, 1, 0));
        step("sub_ovf",   16'h8000, 16'h0001, 3'd1, 1'b1, pk(16'h7FFF, 0, 0, 0, 1));
        step("and",       16'hF0F0, 16'h0FF0, 3'd2, 1'b1, pk(16'h00F0, 0, 0, 0, 0));
        step("or",        16'hF0F0, 16'h0FF0, 3'd3, 1'b1, pk(16'hFFF0, 0, 0, 1, 0));
        step("xor",       16'hF0F0, 16'h0FF0, 3'd4, 1'b1, pk(16'hFF00, 0, 0, 1, 0));
        step("not",       16'hF0F0, 16'h0FF0, 3'd5, 1'b1, pk(16'h0F0F, 0, 0, 0, 0));
        step("shl",       16'h8001, 16'h0001, 3'd6, 1'b1, pk(16'h0002, 1, 0, 0, 0));
        step("shl_zero",  16'h8001, 16'hFFF0, 3'd6, 1'b1, pk(16'h8001, 0, 0, 1, 0));
        step("slt_neg",   16'hFFFF, 16'h0001, 3'd7, 1'b1, pk(16'h0001, 0, 0, 0, 0));
        step("slt_false", 16'h0002, 16'h0001, 3'd7, 1'b1, pk(16'h0000, 0, 1, 0, 0));

        step("mid_add0",  16'd20, 16'h0001, 3'd0, 1'b1, pk(16'd21, 0, 0, 0, 0));
        step("mid_add1",  16'd21, 16'h0001, 3'd0, 1'b1, pk(16'd22, 0, 0, 0, 0));
        step("mid_reset", 16'd22, 16'h0001, 3'd0, 1'b0, RST_VAL);
        step("mid_resume",16'd23, 16'h0001, 3'd0, 1'b1, pk(16'd24, 0, 0, 0, 0));

        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 3'($urandom_range(0, 7));
            if (i % 16 == 0) ra = 16'h8000;
            if (i % 16 == 1) rb = 16'hFFFF;
            step($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), ra, rb, ro, 1'b1,
                 model(ra, rb, ro));
        end

        @(negedge clk);
        check(exp_tag, {sum, carry, zero, neg, ovf}, exp_val);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_in.md
# alu_in

16-bit, eight-operation arithmetic/logic unit with a registered result and status flags. Two 16-bit operands and a 3-bit opcode are sampled on each rising clock edge, and the result plus flags appear one cycle later. It is the datapath execute stage: operands come from the register-read stage and the result feeds write-back.

## Interface
Parameters:
- WIDTH, 16, operand and result width. All behaviour below is defined for 16; other values need not be supported.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- aa, input, 16, operand A.
- bb, input, 16, operand B.
- op, input, 3, opcode.
- sum, output, 16, registered result.
- carry, output, 1, registered carry/borrow flag.
- zero, output, 1, registered flag, set when sum == 0.
- neg, output, 1, registered copy of sum[15].
- ovf, output, 1, registered two's-complement overflow flag.

## Operation
Opcodes (res is the next value of sum):
- 000 ADD: res = aa + bb. carry = bit 16 of the 17-bit sum. ovf = (aa[15] == bb[15]) && (res[15] != aa[15]).
- 001 SUB: res = aa - bb, computed as aa + ~bb + 1. carry = 1 when a borrow occurs (aa < bb unsigned). ovf = (aa[15] != bb[15]) && (res[15] != aa[15]).
- 010 AND: res = aa & bb.
- 011 OR: res = aa | bb.
- 100 XOR: res = aa ^ bb.
- 101 NOT: res = ~aa. bb is ignored.
- 110 SHL: res = aa << bb[3:0]. bb[15:4] is ignored. carry = last bit shifted out, or 0 when the shift amount is 0.
- 111 SLT: res = 16'h0001 if aa < bb as signed values, else 16'h0000.

Flag rules:
- carry and ovf are 0 for all opcodes not listed above as setting them.
- zero and neg are always derived from res.

Arithmetic wraps modulo 2^16; there is no saturation.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N are reflected on sum and the flags after edge N.
- There is no handshake. A new operation is accepted every cycle (throughput 1/cycle).
- Outputs hold their value until the next edge.
- If rst_n == 0 at a rising edge:
  - sum, carry, neg and ovf become 0, and zero becomes 1, consistent with sum == 0.
  - Reset overrides any operation presented in the same cycle.
  - Asserting reset mid-stream discards the in-flight result.
- On the first edge with rst_n == 1, normal operation resumes on the inputs present at that edge.
- Outputs are undefined before the first reset edge. The bench must apply reset first.

## Structure
- Shared package alu_pkg holds:
  - the WIDTH default;
  - an opcode enum: OP_ADD=3'b000, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SLT;
  - a flags struct {carry, zero, neg, ovf}.
- A single combinational sub-module, alu_core, computes res and the flags from aa, bb and op.
- The top level instantiates alu_core and registers its outputs with synchronous active-low reset.

## Test plan
- Reset: hold rst_n=0 for 2 edges with aa=16'h1234, bb=16'h1, op=000 -> sum=0, zero=1, carry=0, neg=0, ovf=0.
- ADD sweep: op=000, bb=1, aa=0..9, one value per cycle -> sum = aa+1 (1..10) one cycle later; zero=0, carry=0 throughout.
- ADD edge cases:
  - aa=16'hFFFF, bb=1 -> sum=0, carry=1, zero=1.
  - aa=16'h7FFF, bb=1 -> sum=16'h8000, ovf=1, neg=1.
- SUB:
  - aa=5, bb=7 -> sum=16'hFFFE, carry(borrow)=1, neg=1.
  - aa=16'h8000, bb=1 -> sum=16'h7FFF, ovf=1.
- Logic and shift with aa=16'hF0F0, bb=16'h0FF0:
  - AND -> 16'h00F0.
  - OR -> 16'hFFF0.
  - XOR -> 16'hFF00.
  - NOT -> 16'h0F0F.
  - SHL with aa=16'h8001, bb=1 -> 16'h0002, carry=1.
- SLT and mid-stream reset:
  - aa=16'hFFFF (-1), bb=1 -> sum=1.
  - aa=2, bb=1 -> sum=0, zero=1.
  - Pull rst_n low for one edge during an ADD stream -> sum=0 at that edge, then sum resumes at aa+1 on the next edge.
